// File: rtl/usr_cmd_sequencer.sv
// Command sequencer for the universal shift register: optional load, N shifts, done pulse.
// Optional feature: define USR_ROTATE_EN to add rotate support (p_dout_fb_i, cmd_rot_i).
module usr_cmd_sequencer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_load_i,
    input  logic             cmd_dir_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic [WIDTH-1:0] cmd_data_i,
    input  logic             cmd_sin_i,
    output logic [1:0]       select_o,
    output logic [WIDTH-1:0] p_din_o,
    output logic             s_left_din_o,
    output logic             s_right_din_o,
    output logic             busy_o,
    output logic             done_o
`ifdef USR_ROTATE_EN
    ,
    input  logic [WIDTH-1:0] p_dout_fb_i,
    input  logic             cmd_rot_i
`endif
);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             sin_q, sin_d;
    logic [WIDTH-1:0] p_din_q, p_din_d;
    logic [1:0]       select_q, select_d;
    logic             s_left_q, s_left_d;
    logic             s_right_q, s_right_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        sin_d   = sin_q;
        p_din_d = p_din_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    dir_d = cmd_dir_i;
                    sin_d = cmd_sin_i;
                    cnt_d = cmd_len_i;
                    if (cmd_load_i) begin
                        p_din_d = cmd_data_i;
                        state_d = StLoad;
                    end else if (cmd_len_i != '0) begin
                        state_d = StShift;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StLoad:  state_d = (cnt_q != '0) ? StShift : StDone;
            StShift: begin
                // Down-counter: the cycle that sees 1 is the last shift.
                if (cnt_q <= LEN_W'(1)) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Outputs are registered, so decode them from the next state.
        select_d  = 2'd0;
        s_left_d  = 1'b0;
        s_right_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        ready_d   = 1'b0;
        unique case (state_d)
            StIdle: ready_d = 1'b1;
            StLoad: begin
                select_d = 2'd3;
                busy_d   = 1'b1;
            end
            StShift: begin
                select_d  = dir_d ? 2'd2 : 2'd1;
                s_left_d  = dir_d & sin_d;
                s_right_d = ~dir_d & sin_d;
                busy_d    = 1'b1;
            end
            StDone:  done_d = 1'b1;
            default: ready_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            sin_q     <= 1'b0;
            p_din_q   <= '0;
            select_q  <= 2'd0;
            s_left_q  <= 1'b0;
            s_right_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            sin_q     <= sin_d;
            p_din_q   <= p_din_d;
            select_q  <= select_d;
            s_left_q  <= s_left_d;
            s_right_q <= s_right_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    assign cmd_ready_o = ready_q;
    assign select_o    = select_q;
    assign p_din_o     = p_din_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

`ifdef USR_ROTATE_EN
    logic rot_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rot_q <= 1'b0;
        end else if (state_q == StIdle && cmd_valid_i) begin
            rot_q <= cmd_rot_i;
        end
    end

    // Rotation feeds the register's own end bit straight back, bypassing the flop.
    assign s_right_din_o = (rot_q && state_q == StShift && !dir_q) ? p_dout_fb_i[0] : s_right_q;
    assign s_left_din_o  = (rot_q && state_q == StShift && dir_q)  ? p_dout_fb_i[WIDTH-1]
                                                                    : s_left_q;
`else
    assign s_right_din_o = s_right_q;
    assign s_left_din_o  = s_left_q;
`endif

endmodule

// File: tb/tb_usr_cmd_sequencer.sv
// Bench for usr_cmd_sequencer: directed and random commands against a behavioural model.
module tb_usr_cmd_sequencer;
    localparam int W  = 4;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_load = 1'b0;
    logic          cmd_dir = 1'b0;
    logic [LW-1:0] cmd_len = '0;
    logic [W-1:0]  cmd_data = '0;
    logic          cmd_sin = 1'b0;
    logic [1:0]    select;
    logic [W-1:0]  p_din;
    logic          s_left_din, s_right_din, busy, done;

    int            nvec = 0;
    int            nerr = 0;
    logic [W-1:0]  usr_q = '0;     // shift register stage driven by the DUT
    logic [W-1:0]  pdin_exp = '0;

    usr_cmd_sequencer #(.WIDTH(W), .LEN_W(LW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_load_i   (cmd_load),
        .cmd_dir_i    (cmd_dir),
        .cmd_len_i    (cmd_len),
        .cmd_data_i   (cmd_data),
        .cmd_sin_i    (cmd_sin),
        .select_o     (select),
        .p_din_o      (p_din),
        .s_left_din_o (s_left_din),
        .s_right_din_o(s_right_din),
        .busy_o       (busy),
        .done_o       (done)
`ifdef USR_ROTATE_EN
        ,
        .p_dout_fb_i  (usr_q),
        .cmd_rot_i    (1'b0)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic set_cmd(input bit ld, input bit dir, input int len, input logic [W-1:0] data,
                           input bit sin);
        cmd_load = ld;
        cmd_dir  = dir;
        cmd_len  = LW'(len);
        cmd_data = data;
        cmd_sin  = sin;
    endtask

    // Present a command with valid for exactly one accepting edge.
    task automatic drive_cmd(input bit ld, input bit dir, input int len,
                             input logic [W-1:0] data, input bit sin);
        @(negedge clk);
        set_cmd(ld, dir, len, data, sin);
        cmd_valid = 1'b1;
        nvec++;
        if (cmd_ready !== 1'b1) begin
            nerr++;
            $display("FAIL ready_before_accept: got %b want 1", cmd_ready);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Walks the cycles following an accepting edge; called just after that edge.
    task automatic test_cmd_cycles(input bit ld, input bit dir, input int len,
                                   input logic [W-1:0] data, input bit sin);
        int k, start, fin, mask;
        logic [6:0] got, exp;
        logic [1:0] esel;
        bit ebusy, edone, er, el;
        mask  = (1 << W) - 1;
        k     = int'(ld) + len + 1;
        start = ld ? int'(data) : int'(usr_q);
        if (ld) pdin_exp = data;
        if (len >= W)  fin = sin ? mask : 0;
        else if (!dir) fin = (start >> len) | (sin ? (((1 << len) - 1) << (W - len)) : 0);
        else           fin = ((start << len) & mask) | (sin ? ((1 << len) - 1) : 0);

        for (int i = 1; i <= k; i++) begin
            @(negedge clk);
            if (i <= int'(ld)) begin
                esel = 2'd3; ebusy = 1; edone = 0; er = 0; el = 0;
            end else if (i <= int'(ld) + len) begin
                esel = dir ? 2'd2 : 2'd1; ebusy = 1; edone = 0; er = !dir && sin; el = dir && sin;
            end else begin
                esel = 2'd0; ebusy = 0; edone = 1; er = 0; el = 0;
            end
            got = {select, busy, done, cmd_ready, s_right_din, s_left_din};
            exp = {esel, ebusy, edone, 1'b0, er, el};
            nvec++;
            if (got !== exp) begin
                nerr++;
                $display("FAIL cycle%0d sel/busy/done/rdy/sr/sl: got %b want %b", i, got, exp);
            end
            nvec++;
            if (p_din !== pdin_exp) begin
                nerr++;
                $display("FAIL cycle%0d p_din: got %h want %h", i, p_din, pdin_exp);
            end
            unique case (select)
                2'd1:    usr_q = {s_right_din, usr_q[W-1:1]};
                2'd2:    usr_q = {usr_q[W-2:0], s_left_din};
                2'd3:    usr_q = p_din;
                default: usr_q = usr_q;
            endcase
        end
        nvec++;
        if (usr_q !== W'(fin)) begin
            nerr++;
            $display("FAIL shreg_final: got %b want %b", usr_q, W'(fin));
        end
    endtask

    task automatic test_idle_after;
        @(negedge clk);
        nvec++;
        if ({cmd_ready, busy, done, select} !== 5'b10000) begin
            nerr++;
            $display("FAIL idle_after_done rdy/busy/done/sel: got %b want 10000",
                     {cmd_ready, busy, done, select});
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        nvec++;
        if ({cmd_ready, busy, done, select, p_din, s_left_din, s_right_din} !== 11'b100_0000_0000) begin
            nerr++;
            $display("FAIL reset_state: got %b want 10000000000",
                     {cmd_ready, busy, done, select, p_din, s_left_din, s_right_din});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        drive_cmd(1, 0, 2, 4'b1101, 1);
        test_cmd_cycles(1, 0, 2, 4'b1101, 1);
        nvec++;
        if (usr_q !== 4'b1111) begin
            nerr++;
            $display("FAIL load_shift_right_value: got %b want 1111", usr_q);
        end
        test_idle_after();
        drive_cmd(0, 1, 3, 4'b0000, 0);
        test_cmd_cycles(0, 1, 3, 4'b0000, 0);
        test_idle_after();
        drive_cmd(0, 0, 0, 4'b0110, 1);
        test_cmd_cycles(0, 0, 0, 4'b0110, 1);
        test_idle_after();
        drive_cmd(1, 1, 4, 4'b1000, 0);
        test_cmd_cycles(1, 1, 4, 4'b1000, 0);
        nvec++;
        if (usr_q !== 4'b0000) begin
            nerr++;
            $display("FAIL load_shift_left_fill: got %b want 0000", usr_q);
        end
        test_idle_after();
    endtask

    task automatic test_random;
        bit ld, dir, sin;
        int len;
        logic [W-1:0] data;
        for (int n = 0; n < 30; n++) begin
            ld   = 1'($urandom_range(0, 1));
            dir  = 1'($urandom_range(0, 1));
            sin  = 1'($urandom_range(0, 1));
            len  = int'($urandom_range(0, (1 << LW) - 1));
            data = W'($urandom);
            drive_cmd(ld, dir, len, data, sin);
            test_cmd_cycles(ld, dir, len, data, sin);
            test_idle_after();
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        set_cmd(1, 0, 3, 4'b1010, 0);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 set_cmd(0, 1, 2, 4'b0101, 1);
        test_cmd_cycles(1, 0, 3, 4'b1010, 0);
        @(negedge clk);
        nvec++;
        if ({cmd_ready, busy, done} !== 3'b100) begin
            nerr++;
            $display("FAIL b2b_idle_gap rdy/busy/done: got %b want 100", {cmd_ready, busy, done});
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        test_cmd_cycles(0, 1, 2, 4'b0101, 1);
        for (int i = 0; i < 3; i++) test_idle_after();
    endtask

    task automatic test_reset_mid_shift;
        drive_cmd(0, 0, 5, 4'b0000, 1);
        @(negedge clk);
        @(negedge clk);
        nvec++;
        if ({select, busy} !== 3'b011) begin
            nerr++;
            $display("FAIL mid_shift_pre_reset sel/busy: got %b want 011", {select, busy});
        end
        #2 rst_n = 1'b0;
        #1;
        nvec++;
        if ({cmd_ready, busy, done, select, p_din, s_left_din, s_right_din} !== 11'b100_0000_0000) begin
            nerr++;
            $display("FAIL async_reset_mid_shift: got %b want 10000000000",
                     {cmd_ready, busy, done, select, p_din, s_left_din, s_right_din});
        end
        pdin_exp = '0;
        @(negedge clk);
        rst_n = 1'b1;
        test_idle_after();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid_shift();
        drive_cmd(1, 0, 1, 4'b0011, 0);
        test_cmd_cycles(1, 0, 1, 4'b0011, 0);
        test_idle_after();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
